// File: rtl/alu_unit.sv
// Buffered integer execution unit: in-order issue queue, ALU, registered CDB slot.
// Build option: define ALU_MUL_EN to add the two-cycle MUL/MULH/MULHSU/MULHU path.
package alu_pkg;
  localparam logic [5:0] OP_ADD    = 6'd1;
  localparam logic [5:0] OP_SUB    = 6'd2;
  localparam logic [5:0] OP_XOR    = 6'd3;
  localparam logic [5:0] OP_OR     = 6'd4;
  localparam logic [5:0] OP_AND    = 6'd5;
  localparam logic [5:0] OP_SLL    = 6'd6;
  localparam logic [5:0] OP_SRL    = 6'd7;
  localparam logic [5:0] OP_SRA    = 6'd8;
  localparam logic [5:0] OP_SLT    = 6'd9;
  localparam logic [5:0] OP_SLTU   = 6'd10;
  localparam logic [5:0] OP_ADDI   = 6'd11;
  localparam logic [5:0] OP_XORI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_ANDI   = 6'd14;
  localparam logic [5:0] OP_SLLI   = 6'd15;
  localparam logic [5:0] OP_SRLI   = 6'd16;
  localparam logic [5:0] OP_SRAI   = 6'd17;
  localparam logic [5:0] OP_SLTI   = 6'd18;
  localparam logic [5:0] OP_SLTIU  = 6'd19;
  localparam logic [5:0] OP_BEQ    = 6'd20;
  localparam logic [5:0] OP_BNE    = 6'd21;
  localparam logic [5:0] OP_BLT    = 6'd22;
  localparam logic [5:0] OP_BGE    = 6'd23;
  localparam logic [5:0] OP_BLTU   = 6'd24;
  localparam logic [5:0] OP_BGEU   = 6'd25;
  localparam logic [5:0] OP_JALR   = 6'd26;
  localparam logic [5:0] OP_MUL    = 6'd27;
  localparam logic [5:0] OP_MULH   = 6'd28;
  localparam logic [5:0] OP_MULHSU = 6'd29;
  localparam logic [5:0] OP_MULHU  = 6'd30;
endpackage

module alu_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ROB_W  = 4,
  parameter int OPC_W  = 6,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             RS_sgn,
  input  logic [OPC_W-1:0] RS_opcode,
  input  logic [ROB_W-1:0] RS_ROB_name,
  input  logic [XLEN-1:0]  RS_lhs,
  input  logic [XLEN-1:0]  RS_rhs,
  output logic             RS_full,
  input  logic             CDB_gnt,
  output logic             CDB_sgn,
  output logic [XLEN-1:0]  CDB_result,
  output logic [ROB_W-1:0] CDB_ROB_name
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OPC_W-1:0] op;
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } ent_t;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;
`else
  typedef enum logic {S_IDLE} state_e;
`endif

  state_e state_q, state_d;

  ent_t           q_mem [QDEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic             sgn_q, sgn_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [ROB_W-1:0] tag_q, tag_d;

  ent_t in_e, cand;
  logic full, empty, slot_free, idle;
  logic take, pop, push, cand_mul, wr_alu, mul_done;
  logic [XLEN-1:0] mul_res;

  function automatic logic [XLEN-1:0] alu_f(
    input logic [OPC_W-1:0] op,
    input logic [XLEN-1:0]  a,
    input logic [XLEN-1:0]  b
  );
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD, OP_ADDI:   r = a + b;
      OP_SUB:            r = a - b;
      OP_XOR, OP_XORI:   r = a ^ b;
      OP_OR,  OP_ORI:    r = a | b;
      OP_AND, OP_ANDI:   r = a & b;
      OP_SLL, OP_SLLI:   r = a << b[4:0];
      OP_SRL, OP_SRLI:   r = a >> b[4:0];
      OP_SRA, OP_SRAI:   r = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT, OP_SLTI:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU, OP_SLTIU: r = {{(XLEN-1){1'b0}}, a < b};
      OP_BEQ:            r = {{(XLEN-1){1'b0}}, a == b};
      OP_BNE:            r = {{(XLEN-1){1'b0}}, a != b};
      OP_BLT:            r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_BGE:            r = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
      OP_BLTU:           r = {{(XLEN-1){1'b0}}, a < b};
      OP_BGEU:           r = {{(XLEN-1){1'b0}}, a >= b};
      OP_JALR:           r = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
      default:           r = '0;
    endcase
    return r;
  endfunction

  assign in_e      = '{op: RS_opcode, tag: RS_ROB_name, a: RS_lhs, b: RS_rhs};
  assign full      = (cnt_q == CW'(QDEPTH));
  assign empty     = (cnt_q == '0);
  assign slot_free = !sgn_q || CDB_gnt;
  assign idle      = (state_q == S_IDLE);
  assign cand      = empty ? in_e : q_mem[head_q];
  assign RS_full   = full;

  // An empty queue lets the incoming op bypass straight to dispatch.
  assign take   = !clr && slot_free && idle && (!empty || RS_sgn);
  assign pop    = take && !empty;
  assign push   = !clr && RS_sgn && !full && !(take && empty);
  assign wr_alu = take && !cand_mul;

`ifdef ALU_MUL_EN
  ent_t mul_q;
  logic [2*XLEN-1:0] ea, eb, prod;
  logic sa, sb;

  assign cand_mul = (cand.op == OP_MUL) || (cand.op == OP_MULH) ||
                    (cand.op == OP_MULHSU) || (cand.op == OP_MULHU);
  assign mul_done = !clr && (state_q == S_MUL) && slot_free;

  // Sign/zero extension to 2*XLEN makes one multiplier serve all variants.
  always_comb begin
    sa      = (mul_q.op == OP_MULH) || (mul_q.op == OP_MULHSU);
    sb      = (mul_q.op == OP_MULH);
    ea      = {{XLEN{sa & mul_q.a[XLEN-1]}}, mul_q.a};
    eb      = {{XLEN{sb & mul_q.b[XLEN-1]}}, mul_q.b};
    prod    = ea * eb;
    mul_res = (mul_q.op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mul_q <= '0;
    else if (rdy && take && cand_mul) mul_q <= cand;
  end
`else
  assign cand_mul = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  always_comb begin
    state_d = state_q;
    if (clr) state_d = S_IDLE;
`ifdef ALU_MUL_EN
    else if (take && cand_mul) state_d = S_MUL;
    else if (mul_done) state_d = S_IDLE;
`endif
  end

  always_comb begin
    sgn_d = sgn_q;
    res_d = res_q;
    tag_d = tag_q;
    if (clr) begin
      sgn_d = 1'b0;
    end else if (wr_alu) begin
      sgn_d = 1'b1;
      res_d = alu_f(cand.op, cand.a, cand.b);
      tag_d = cand.tag;
    end else if (mul_done) begin
      sgn_d = 1'b1;
      res_d = mul_res;
`ifdef ALU_MUL_EN
      tag_d = mul_q.tag;
`endif
    end else if (CDB_gnt) begin
      sgn_d = 1'b0;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && push) q_mem[tail_q] <= in_e;
  end

  assign CDB_sgn      = sgn_q;
  assign CDB_result   = res_q;
  assign CDB_ROB_name = tag_q;

endmodule
